// File: rtl/vdp_pkg.sv
// vdp_pkg: shared constants and types for the
// VDP CPU port controller and its register file.
package vdp_pkg;

  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_CTRL = 1'b1;

  localparam logic [2:0] REG_R0 = 3'd0;
  localparam logic [2:0] REG_R1 = 3'd1;
  localparam logic [2:0] REG_R2 = 3'd2;
  localparam logic [2:0] REG_R3 = 3'd3;
  localparam logic [2:0] REG_R4 = 3'd4;
  localparam logic [2:0] REG_R5 = 3'd5;
  localparam logic [2:0] REG_R6 = 3'd6;
  localparam logic [2:0] REG_R7 = 3'd7;

  localparam logic [1:0] MODE_TEXT = 2'd0;
  localparam logic [1:0] MODE_G1   = 2'd1;
  localparam logic [1:0] MODE_G2   = 2'd2;
  localparam logic [1:0] MODE_MC   = 2'd3;

  localparam int STAT_F = 7;

  localparam int R1_BL = 6;
  localparam int R1_IE = 5;
  localparam int R1_M1 = 4;
  localparam int R1_M2 = 3;
  localparam int R0_M3 = 1;

  localparam int CMD_REG  = 7;
  localparam int CMD_NORD = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP
  } rd_state_t;

  // M1 wins over M3, M3 wins over M2.
  function automatic logic [1:0] mode_decode(
    input logic m1,
    input logic m2,
    input logic m3
  );
    logic [1:0] md;
    md = MODE_G1;
    priority case (1'b1)
      m1:      md = MODE_TEXT;
      m3:      md = MODE_G2;
      m2:      md = MODE_MC;
      default: md = MODE_G1;
    endcase
    return md;
  endfunction

endpackage

// File: rtl/vdp_regfile.sv
// vdp_regfile: write-only VDP registers R0..R7 and
// the table base / mode / colour decode they drive.
module vdp_regfile
  import vdp_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  idx,
  input  logic [7:0]  wdata,
  output logic [1:0]  mode,
  output logic [13:0] name_table_addr,
  output logic [13:0] color_table_addr,
  output logic [13:0] font_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pattern_table_addr,
  output logic [3:0]  text_color,
  output logic [3:0]  back_color,
  output logic        video_on,
  output logic        irq_en
);

  logic [7:0] regs [NREGS];
  logic       unused_bits;

  // register storage, one byte written per access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[idx] <= wdata;
    end
  end

  // table bases, colours and control bits
  always_comb begin
    name_table_addr  = {regs[REG_R2][3:0], 10'b0};
    color_table_addr = {regs[REG_R3], 6'b0};
    font_addr        = {regs[REG_R4][2:0], 11'b0};
    sprite_attr_addr = {regs[REG_R5][6:0], 7'b0};
    sprite_pattern_table_addr =
      {regs[REG_R6][2:0], 11'b0};
    text_color = regs[REG_R7][7:4];
    back_color = regs[REG_R7][3:0];
    video_on   = regs[REG_R1][R1_BL];
    irq_en     = regs[REG_R1][R1_IE];
    mode = mode_decode(regs[REG_R1][R1_M1],
                       regs[REG_R1][R1_M2],
                       regs[REG_R0][R0_M3]);
  end

  assign unused_bits = ^{regs[REG_R0][7:2],
                         regs[REG_R0][0],
                         regs[REG_R1][7],
                         regs[REG_R1][2:0],
                         regs[REG_R2][7:4],
                         regs[REG_R4][7:3],
                         regs[REG_R5][7],
                         regs[REG_R6][7:3]};

endmodule

// File: rtl/vdp_port_ctrl.sv
// vdp_port_ctrl: Z80 data/control port decode, VRAM
// address counter, read-ahead buffer and status flag.
module vdp_port_ctrl
  import vdp_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_sel,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait,
  input  logic              vblank,
  output logic [ADDR_W-1:0] vga_addr,
  output logic [7:0]        vga_din,
  output logic              vga_wr,
  output logic              vga_rd,
  input  logic [7:0]        vga_dout,
  output logic [1:0]        mode,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       color_table_addr,
  output logic [13:0]       font_addr,
  output logic [13:0]       sprite_attr_addr,
  output logic [13:0]       sprite_pattern_table_addr,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  output logic              video_on,
  output logic              n_int
);

  rd_state_t         state;
  logic              latch;
  logic [7:0]        first_byte;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rbuf;
  logic              flag_f;
  logic              irq_en;

  logic              idle;
  logic              wr_go;
  logic              rd_go;
  logic              ctrl_wr;
  logic              data_wr;
  logic              data_rd;
  logic              stat_rd;
  logic              reg_we;
  logic              addr_set;
  logic              ahead;
  logic [ADDR_W-1:0] new_addr;

  // a write beats a read; nothing is taken mid read-ahead
  always_comb begin
    idle     = (state == ST_IDLE);
    wr_go    = cpu_wr & idle;
    rd_go    = cpu_rd & ~cpu_wr & idle;
    ctrl_wr  = wr_go & (cpu_sel == SEL_CTRL);
    data_wr  = wr_go & (cpu_sel == SEL_DATA);
    data_rd  = rd_go & (cpu_sel == SEL_DATA);
    stat_rd  = rd_go & (cpu_sel == SEL_CTRL);
    reg_we   = ctrl_wr & latch & cpu_din[CMD_REG];
    addr_set = ctrl_wr & latch & ~cpu_din[CMD_REG];
    ahead    = (addr_set & ~cpu_din[CMD_NORD])
             | data_rd;
    new_addr = ADDR_W'({cpu_din[5:0], first_byte});
  end

  vdp_regfile #(
    .NREGS(NREGS)
  ) u_regs (
    .clk                      (clk),
    .reset                    (reset),
    .we                       (reg_we),
    .idx                      (cpu_din[2:0]),
    .wdata                    (first_byte),
    .mode                     (mode),
    .name_table_addr          (name_table_addr),
    .color_table_addr         (color_table_addr),
    .font_addr                (font_addr),
    .sprite_attr_addr         (sprite_attr_addr),
    .sprite_pattern_table_addr(sprite_pattern_table_addr),
    .text_color               (text_color),
    .back_color               (back_color),
    .video_on                 (video_on),
    .irq_en                   (irq_en)
  );

  // two-byte control sequence latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch      <= 1'b0;
      first_byte <= '0;
    end else if (ctrl_wr) begin
      latch <= ~latch;
      if (!latch) begin
        first_byte <= cpu_din;
      end
    end else if (data_wr | data_rd | stat_rd) begin
      latch <= 1'b0;
    end
  end

  // status flag: vblank set wins over read clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_f <= 1'b0;
    end else if (vblank) begin
      flag_f <= 1'b1;
    end else if (stat_rd) begin
      flag_f <= 1'b0;
    end
  end

  // registered CPU read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_dout <= '0;
    end else if (data_rd) begin
      cpu_dout <= rbuf;
    end else if (stat_rd) begin
      cpu_dout <= {flag_f, 7'b0};
    end
  end

  // VRAM access FSM with address counter and rbuf
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cpu_wait <= 1'b0;
      addr     <= '0;
      rbuf     <= '0;
      vga_addr <= '0;
      vga_din  <= '0;
      vga_wr   <= 1'b0;
      vga_rd   <= 1'b0;
    end else begin
      vga_wr <= 1'b0;
      vga_rd <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (data_wr) begin
            vga_wr   <= 1'b1;
            vga_addr <= addr;
            vga_din  <= cpu_din;
            rbuf     <= cpu_din;
            addr     <= addr + ADDR_W'(1);
          end
          if (addr_set) begin
            addr <= new_addr;
          end
          if (ahead) begin
            state    <= ST_RD;
            cpu_wait <= 1'b1;
            vga_rd   <= 1'b1;
            vga_addr <= addr_set ? new_addr : addr;
          end
        end
        ST_RD: begin
          state <= ST_CAP;
        end
        ST_CAP: begin
          rbuf     <= vga_dout;
          addr     <= addr + ADDR_W'(1);
          state    <= ST_IDLE;
          cpu_wait <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          cpu_wait <= 1'b0;
        end
      endcase
    end
  end

  assign n_int = ~(flag_f & irq_en);

endmodule
